regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader that walks a contiguous index range of the 32x64 register file through one of its combinational read ports.
- Streams each register value out over a valid/ready interface.
- Used for debug dump, context save, and end-of-test state checking.
- Sits beside the register file and owns one read-address port while busy.

Parameters:
- XLEN, 64, data width of one register and of the dump stream.
- NUM_REGS, 32, number of architectural registers.
- IDX_W, 5, index width (log2 of NUM_REGS).
- ZERO_X0, 1, when 1 the beat for index 0 carries all zeros regardless of rf_read_data.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a dump; sampled only in IDLE.
- first_idx  input  IDX_W  first register index, captured on accepted start.
- last_idx  input  IDX_W  last register index (inclusive), captured on accepted start.
- abort  input  1  synchronous cancel of an in-progress dump.
- rf_read_register  output  IDX_W  read address to the register file port.
- rf_read_data  input  XLEN  combinational read data returned for rf_read_register.
- dump_valid  output  1  output beat valid.
- dump_ready  input  1  downstream accepts the beat.
- dump_idx  output  IDX_W  register index of the current beat.
- dump_data  output  XLEN  register value of the current beat.
- dump_last  output  1  current beat is the final one of the range.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final beat handshakes, or after an empty range.

Behaviour:
- States: IDLE, FILL, STREAM.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - dump_valid, dump_last, busy, done = 0.
  - dump_idx, dump_data, rf_read_register = 0.
  - Internal index counter = 0.
- rf_read_register is driven from the internal next-index counter in every state.
- IDLE:
  - start=1 with first_idx <= last_idx: capture first_idx and last_idx, counter <= first_idx, go to FILL.
  - start=1 with first_idx > last_idx: stay in IDLE, pulse done next cycle, no beats.
- FILL (buffer empty):
  - Capture rf_read_data into dump_data; dump_idx <= counter.
  - dump_last <= (counter == last).
  - dump_valid <= 1; go to STREAM.
  - If counter != last, increment counter.
- STREAM with dump_valid=1 and dump_ready=0:
  - All outputs hold stable; counter holds.
- STREAM with a handshake (dump_valid & dump_ready):
  - If dump_last=0: load the next beat exactly as in FILL in the same edge, keeping dump_valid=1. Throughput is one beat per cycle.
  - If dump_last=1: dump_valid <= 0, go to IDLE, pulse done for the following cycle.
- Latency: start sampled at edge N; first beat is valid after edge N+1.
- Counter never wraps:
  - The counter is not incremented when it equals last.
  - last_idx = NUM_REGS-1 is legal.
- ZERO_X0=1: any beat with index 0 carries dump_data = 0.
- Data is a snapshot at capture time:
  - A register-file write to an index already captured does not update dump_data.
  - A same-edge write to the index being captured yields the pre-write value, since the register file read is combinational from current contents.
- abort=1 in FILL or STREAM: at next edge go to IDLE, dump_valid=0, dump_last=0, no done pulse. abort has priority over a simultaneous handshake. abort in IDLE has no effect.
- start while busy=1 is ignored.
- first_idx and last_idx changing mid-dump have no effect.
- busy = 1 in FILL and STREAM. It falls in the same edge that raises done.

Test Plan:
- Preload regs 0..31 with 0x1000+i, ZERO_X0=1, first=0, last=31, dump_ready=1 -> 32 consecutive beats, idx 0..31, data 0 then 0x1001..0x101F, dump_last only on idx 31, done one cycle after.
- first=5, last=7, dump_ready toggling 1,0,0,1,0,1 -> beats idx 5,6,7 with data held stable across stalls; exactly 3 handshakes; done once.
- first=9, last=3 -> zero beats, done pulses one cycle after start, busy stays 0.
- first=last=31 -> single beat idx 31 with dump_last=1; counter does not wrap; rf_read_register stays 31.
- Range 0..15 with abort asserted on the 4th beat while dump_ready=1 -> that beat counts as not accepted, IDLE next cycle, no done; a new start then dumps correctly from first_idx.
- rst_n pulled low mid-STREAM asynchronously -> outputs zero immediately without a clock edge; after release the block stays in IDLE until start.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Purpose : bundles the dump reader's control, register-file read port and dump stream.
// Latency : none (wiring only).
// Backpres: dump_valid/dump_ready; the reader holds a stalled beat until dump_ready.
// Ports   : master = the dump reader, slave = the requester / register file / stream sink.
interface regfile_dump_reader_if #(
    parameter int XLEN  = 64,
    parameter int IDX_W = 5
);
    // control
    logic             start;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] last_idx;
    logic             abort;
    logic             busy;
    logic             done;
    // register-file read port
    logic [IDX_W-1:0] rf_read_register;
    logic [XLEN-1:0]  rf_read_data;
    // dump stream
    logic             dump_valid;
    logic             dump_ready;
    logic [IDX_W-1:0] dump_idx;
    logic [XLEN-1:0]  dump_data;
    logic             dump_last;

    modport master (
        input  start, first_idx, last_idx, abort, rf_read_data, dump_ready,
        output rf_read_register, dump_valid, dump_idx, dump_data, dump_last, busy, done
    );

    modport slave (
        output start, first_idx, last_idx, abort, rf_read_data, dump_ready,
        input  rf_read_register, dump_valid, dump_idx, dump_data, dump_last, busy, done
    );
endinterface

// File: rtl/regfile_dump_reader.sv
// Purpose : walks an inclusive index range of the register file and streams each value out.
// Latency : start sampled at edge N, first beat valid after edge N+1; one beat per cycle after.
// Backpres: a beat with dump_ready low holds all outputs and the read counter stable.
// Ports   : clk, rst_n (async active-low); bus (master modport) carries start/first_idx/
//           last_idx/abort, the rf read port and the dump_* stream plus busy/done.
module regfile_dump_reader #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int IDX_W    = 5,
    parameter bit ZERO_X0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_dump_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(NUM_REGS - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] dump_idx_q, dump_idx_d;
    logic [XLEN-1:0]  dump_data_q, dump_data_d;
    logic             dump_valid_q, dump_valid_d;
    logic             dump_last_q, dump_last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [XLEN-1:0]  cap_data;
    logic             load_beat;

    // The read port always follows the next-index counter, so rf_read_data is
    // already the value for cnt_q whenever a beat is captured.
    assign bus.rf_read_register = cnt_q;
    assign bus.dump_valid       = dump_valid_q;
    assign bus.dump_idx         = dump_idx_q;
    assign bus.dump_data        = dump_data_q;
    assign bus.dump_last        = dump_last_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;

    always_comb begin
        cap_data = bus.rf_read_data;
        if (ZERO_X0 && (cnt_q == '0)) begin
            cap_data = '0;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        dump_idx_d   = dump_idx_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        done_d       = 1'b0;
        load_beat    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.first_idx <= bus.last_idx) begin
                        // Indices past the end of the file are clamped to the last register.
                        last_d  = (bus.last_idx > MAX_IDX) ? MAX_IDX : bus.last_idx;
                        cnt_d   = bus.first_idx;
                        state_d = FILL;
                    end else begin
                        // Empty range: report completion without producing beats.
                        done_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.abort) begin
                    state_d      = IDLE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                end else begin
                    load_beat = 1'b1;
                end
            end
            STREAM: begin
                // abort wins over a handshake in the same cycle: that beat is dropped.
                if (bus.abort) begin
                    state_d      = IDLE;
                    dump_valid_d = 1'b0;
                    dump_last_d  = 1'b0;
                end else if (dump_valid_q && bus.dump_ready) begin
                    if (dump_last_q) begin
                        state_d      = IDLE;
                        dump_valid_d = 1'b0;
                        dump_last_d  = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        load_beat = 1'b1;
                    end
                end
            end
            default: begin
                state_d      = IDLE;
                dump_valid_d = 1'b0;
                dump_last_d  = 1'b0;
            end
        endcase

        if (load_beat) begin
            dump_data_d  = cap_data;
            dump_idx_d   = cnt_q;
            dump_last_d  = (cnt_q == last_q);
            dump_valid_d = 1'b1;
            state_d      = STREAM;
            // Saturate at last so a range ending at the top register never wraps.
            if (cnt_q != last_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // busy tracks the next state so it drops on the same edge that raises done.
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_q       <= '0;
            dump_idx_q   <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            dump_idx_q   <= dump_idx_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Purpose : directed self-checking bench for regfile_dump_reader.
// Latency : n/a.
// Backpres: drives dump_ready from per-vector patterns; stalls check beat stability.
module tb_regfile_dump_reader;

    logic clk;
    logic rst_n;

    regfile_dump_reader_if #(.XLEN(64), .IDX_W(5)) bus ();

    regfile_dump_reader #(
        .XLEN(64), .NUM_REGS(32), .IDX_W(5), .ZERO_X0(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [63:0] rf [32];
    assign bus.rf_read_data = rf[bus.rf_read_register];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  f;
        logic [4:0]  l;
        logic [15:0] pat;    // dump_ready for cycle c is pat[c % 16]
        int          beats;
        logic [63:0] base;   // rf[i] = base + i
    } vec_t;

    vec_t vecs [7];

    // Expected beat value: index 0 always reads as zero.
    function automatic logic [63:0] exp_val(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : rf[idx];
    endfunction

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l,
                            input logic [15:0] pat, input int exp_beats);
        int          k;
        int          dones;
        bit          fin;
        logic        pv, pr;
        logic [4:0]  pidx;
        logic [63:0] pdata;
        logic [4:0]  eidx;
        @(negedge clk);
        bus.start = 1'b1; bus.first_idx = f; bus.last_idx = l;
        bus.abort = 1'b0; bus.dump_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        // Changing the range mid-dump must have no effect.
        bus.first_idx = ~f; bus.last_idx = ~l;
        if (exp_beats == 0) begin
            check("empty done", bus.done, 1'b1);
            check("empty busy", bus.busy, 1'b0);
            check("empty valid", bus.dump_valid, 1'b0);
            @(negedge clk);
            check("empty done pulse", bus.done, 1'b0);
            check("empty busy after", bus.busy, 1'b0);
            return;
        end
        check("fill valid", bus.dump_valid, 1'b0);
        check("fill busy", bus.busy, 1'b1);
        check("fill rd addr", bus.rf_read_register, f);
        k = 0; dones = 0; fin = 1'b0; pv = 1'b0; pr = 1'b0; pidx = '0; pdata = '0;
        for (int c = 1; c < 300 && !fin; c++) begin
            @(negedge clk);
            bus.dump_ready = pat[c % 16];
            if (bus.done) begin
                fin = 1'b1;
                check("beat count", k, exp_beats);
                check("busy at done", bus.busy, 1'b0);
                check("valid at done", bus.dump_valid, 1'b0);
            end else begin
                check("busy", bus.busy, 1'b1);
                if (c == 1) check("first beat latency", bus.dump_valid, 1'b1);
                if (bus.dump_valid) begin
                    eidx = f + 5'(k);
                    check("idx", bus.dump_idx, eidx);
                    check("data", bus.dump_data, exp_val(eidx));
                    check("last", bus.dump_last, eidx == l);
                    if (pv && !pr) begin
                        check("stall idx", bus.dump_idx, pidx);
                        check("stall data", bus.dump_data, pdata);
                    end
                    if (bus.dump_ready) k++;
                end
            end
            pv = bus.dump_valid; pr = bus.dump_ready;
            pidx = bus.dump_idx; pdata = bus.dump_data;
        end
        check("done seen", fin, 1'b1);
        @(negedge clk);
        bus.dump_ready = 1'b0;
        check("done single pulse", bus.done, 1'b0);
        check("idle busy", bus.busy, 1'b0);
        check("idle rd addr", bus.rf_read_register, l);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{f: 5'd0,  l: 5'd31, pat: 16'hFFFF, beats: 32, base: 64'h1000};
        vecs[1] = '{f: 5'd5,  l: 5'd7,  pat: 16'h9A69, beats: 3,  base: 64'h1000};
        vecs[2] = '{f: 5'd9,  l: 5'd3,  pat: 16'hFFFF, beats: 0,  base: 64'h1000};
        vecs[3] = '{f: 5'd31, l: 5'd31, pat: 16'hFFFF, beats: 1,  base: 64'h1000};
        vecs[4] = '{f: 5'd0,  l: 5'd0,  pat: 16'hFFFF, beats: 1,  base: 64'hFEDC_BA98_7654_0000};
        vecs[5] = '{f: 5'd28, l: 5'd31, pat: 16'h5555, beats: 4,  base: 64'hFEDC_BA98_7654_0000};
        vecs[6] = '{f: 5'd10, l: 5'd12, pat: 16'h0F0F, beats: 3,  base: 64'h8000_0000_0000_0001};

        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rst_n = 1'b0;
        bus.start = 1'b0; bus.first_idx = '0; bus.last_idx = '0;
        bus.abort = 1'b0; bus.dump_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst valid", bus.dump_valid, 1'b0);
        check("rst last", bus.dump_last, 1'b0);
        check("rst busy", bus.busy, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst idx", bus.dump_idx, 5'd0);
        check("rst data", bus.dump_data, 64'd0);
        check("rst rd addr", bus.rf_read_register, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < 32; j++) rf[j] = vecs[v].base + 64'(j);
            run_dump(vecs[v].f, vecs[v].l, vecs[v].pat, vecs[v].beats);
        end

        // Abort on the 4th beat while dump_ready is high; a start while busy is ignored.
        for (int j = 0; j < 32; j++) rf[j] = 64'h1000 + 64'(j);
        @(negedge clk);
        bus.start = 1'b1; bus.first_idx = 5'd0; bus.last_idx = 5'd15; bus.dump_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check("abort seq valid", bus.dump_valid, 1'b1);
            check("abort seq idx", bus.dump_idx, 5'(c - 1));
            bus.start = (c == 2);
            bus.first_idx = 5'd20; bus.last_idx = 5'd25;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort valid", bus.dump_valid, 1'b0);
        check("abort last", bus.dump_last, 1'b0);
        check("abort busy", bus.busy, 1'b0);
        check("abort no done", bus.done, 1'b0);
        bus.abort = 1'b1;   // abort in IDLE has no effect
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort no late done", bus.done, 1'b0);
        check("idle abort busy", bus.busy, 1'b0);
        run_dump(5'd0, 5'd2, 16'hFFFF, 3);

        // Asynchronous reset in the middle of a stalled stream.
        @(negedge clk);
        bus.start = 1'b1; bus.first_idx = 5'd10; bus.last_idx = 5'd20; bus.dump_ready = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("pre-rst valid", bus.dump_valid, 1'b1);
        check("pre-rst idx", bus.dump_idx, 5'd10);
        #2 rst_n = 1'b0;
        #1;
        check("async rst valid", bus.dump_valid, 1'b0);
        check("async rst idx", bus.dump_idx, 5'd0);
        check("async rst data", bus.dump_data, 64'd0);
        check("async rst last", bus.dump_last, 1'b0);
        check("async rst busy", bus.busy, 1'b0);
        check("async rst rd addr", bus.rf_read_register, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post-rst busy", bus.busy, 1'b0);
            check("post-rst valid", bus.dump_valid, 1'b0);
        end
        run_dump(5'd3, 5'd4, 16'hFFFF, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
